// File: rtl/flag_stack_reg.sv
// -----------------------------------------------------------------------------
// flag_stack_reg
//
// Condition-flag register with a per-bit write enable and a LIFO save/restore
// stack. The live flags sit between the ALU flag outputs and the branch,
// compare and carry-in consumers. Push saves the live flags and pop restores
// them, so flag state survives subroutine calls.
//
// Parameters:
//   NUM_FLAGS   - number of flag bits (bit 0 = carry, 1 = LT, 2 = OV by default)
//   DEPTH       - number of stack entries (>= 1)
//   RESET_FLAGS - value of the live flags after reset
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   flag_in   in   new flag values
//   flag_we   in   per-bit write enable for the live flags
//   push      in   save the live flags onto the stack
//   pop       in   restore the live flags from the top of the stack
//   err_clr   in   clear the sticky error bits
//   flag_out  out  live flags (bit 0 also feeds ALU carry-in)
//   depth     out  number of occupied stack entries
//   full      out  depth == DEPTH
//   empty     out  depth == 0
//   ovf_err   out  sticky, set by a push while full
//   unf_err   out  sticky, set by a pop while empty
// -----------------------------------------------------------------------------
module flag_stack_reg #(
  parameter int                      NUM_FLAGS   = 3,
  parameter int                      DEPTH       = 4,
  parameter logic [NUM_FLAGS-1:0]    RESET_FLAGS = '0,
  localparam int                     DW          = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FLAGS-1:0] flag_in,
  input  logic [NUM_FLAGS-1:0] flag_we,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 err_clr,
  output logic [NUM_FLAGS-1:0] flag_out,
  output logic [DW-1:0]        depth,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf_err,
  output logic                 unf_err
);

  // Stack index width; a 1-entry stack still needs a 1-bit index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic [NUM_FLAGS-1:0] stack_mem [DEPTH];

  // Controls are forced low while reset is held so X on them cannot leak in.
  logic [NUM_FLAGS-1:0] flag_we_g;
  logic                 push_g, pop_g, err_clr_g;

  assign flag_we_g = flag_we & {NUM_FLAGS{rst_n}};
  assign push_g    = push    & rst_n;
  assign pop_g     = pop     & rst_n;
  assign err_clr_g = err_clr & rst_n;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);

  // Push/pop together cancel out: neither acts on the stack nor raises an error.
  logic push_only, pop_only;
  logic do_push, do_pop;

  assign push_only = push_g & ~pop_g;
  assign pop_only  = pop_g  & ~push_g;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only  & ~empty;

  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - DW'(1));

  // Per-bit masked write of the live flags.
  logic [NUM_FLAGS-1:0] flags_wr;

  generate
    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag_bit
      assign flags_wr[gi] = flag_we_g[gi] ? flag_in[gi] : flags_q[gi];
    end
  endgenerate

  always_comb begin
    flags_d = flags_wr;
    depth_d = depth_q;

    if (pop_only) begin
      // Pop has priority over flag writes, even when the stack is empty.
      flags_d = do_pop ? stack_mem[rd_idx] : flags_q;
      if (do_pop) begin
        depth_d = depth_q - DW'(1);
      end
    end else if (do_push) begin
      depth_d = depth_q + DW'(1);
    end
  end

  // Error set wins over a simultaneous clear.
  always_comb begin
    ovf_d = (push_only & full)  | (ovf_q & ~err_clr_g);
    unf_d = (pop_only  & empty) | (unf_q & ~err_clr_g);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; depth alone defines which entries are valid.
  // The saved copy is the pre-edge live value, not any same-cycle write.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[wr_idx] <= flags_q;
    end
  end

  assign flag_out = flags_q;
  assign depth    = depth_q;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule

// File: doc/flag_stack_reg.md
Name: flag_stack_reg

Overview:
- Parametrised condition-flag register for the datapath: holds NUM_FLAGS status bits, for example LT, OV and the carry fed back to the ALU.
- Each flag has its own write enable, so any combination of flags can be updated in the same cycle.
- Adds a DEPTH-entry save/restore stack so flag state survives subroutine calls: push saves the live flags, pop restores them.
- Sits between the ALU flag outputs and the branch, compare and carry-in consumers.

Parameters:
NUM_FLAGS, 3, number of flag bits (bit 0 = carry, bit 1 = LT, bit 2 = OV at the default).
DEPTH, 4, number of stack entries; must be at least 1.
RESET_FLAGS, 0, value loaded into the live flags on reset (NUM_FLAGS bits wide).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
flag_in  in  NUM_FLAGS  new flag values from the ALU and compare logic.
flag_we  in  NUM_FLAGS  per-bit write enable for the live flags.
push  in  1  save the live flags onto the stack.
pop  in  1  restore the live flags from the top of the stack.
err_clr  in  1  clear the sticky error bits.
flag_out  out  NUM_FLAGS  live flags (bit 0 also drives ALU carry-in).
depth  out  $clog2(DEPTH+1)  number of occupied stack entries.
full  out  1  high when depth == DEPTH.
empty  out  1  high when depth == 0.
ovf_err  out  1  sticky; set by a push while full.
unf_err  out  1  sticky; set by a pop while empty.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - flag_out = RESET_FLAGS, depth = 0, empty = 1, full = 0, ovf_err = 0, unf_err = 0.
  - Stack storage contents are don't-care after reset.
- All updates happen on the rising edge of clk and are visible on the next cycle (1-cycle latency).
- No clock edge with all enables low: every register holds its value.
- Live flag write: for each bit i with flag_we[i] = 1, flag_out[i] takes flag_in[i]. Bits with flag_we[i] = 0 hold.
- Push only (push = 1, pop = 0, not full):
  - stack[depth] takes the current (pre-edge) flag_out, then depth increments.
  - Any flag_we writes in the same cycle still update the live flags. The saved copy is the pre-write value.
- Pop only (pop = 1, push = 0, not empty):
  - flag_out takes stack[depth-1], then depth decrements.
  - Pop has priority: flag_we is ignored in that cycle.
- Push and pop asserted together:
  - Stack is untouched, depth is unchanged, no error is raised.
  - flag_we writes proceed normally.
- Push while full:
  - Stack and depth are unchanged and ovf_err is set.
  - flag_we writes proceed normally.
- Pop while empty:
  - flag_out is unchanged and unf_err is set.
  - flag_we is still ignored, because pop priority applies.
- err_clr:
  - Clears ovf_err and unf_err on the next edge.
  - If an error event occurs in the same cycle, the set wins and the bit reads 1.
- full and empty are combinational decodes of the depth register, with no extra latency.
- Stack pointer behaviour:
  - The pointer never wraps; depth stays within 0..DEPTH under all inputs.
  - Data is LIFO: the value pushed most recently is the value popped first.
- X-safety: push, pop, flag_we and err_clr are treated as 0 while rst_n is low. After rst_n deasserts, the first edge acts normally.
- Reset asserted mid-sequence (for example between a push and its matching pop) discards all saved entries; depth returns to 0.

Test Plan:
- Reset, then flag_we=3'b101 with flag_in=3'b111 -> flag_out=3'b101 next cycle. Then flag_we=3'b010 with flag_in=3'b000 -> flag_out=3'b101; writing 0 into the already-0 LT bit leaves bits 0 and 2 held.
- Push and write together: flag_out=3'b011, push=1, flag_we=3'b111, flag_in=3'b100 -> flag_out=3'b100, depth=1. Next cycle pop=1, flag_we=3'b111, flag_in=3'b111 -> flag_out=3'b011 (the write is ignored), depth=0, empty=1.
- Full stack: push 4 times with flags 1, 2, 3, 4 -> full=1, depth=4. A 5th push -> ovf_err=1, depth=4. Then 4 pops -> flag_out reads 4, 3, 2, 1 in order; empty=1.
- Underflow: pop on an empty stack with flag_out=3'b010 -> unf_err=1, flag_out=3'b010, depth=0. Then err_clr=1 and pop=1 in the same cycle -> unf_err stays 1. err_clr alone -> unf_err=0.
- Simultaneous push and pop at depth=2 with flag_we=3'b001, flag_in=3'b001 -> depth=2, no error, flag_out[0]=1.
- Mid-operation reset: depth=3, drop rst_n low between clock edges -> flag_out=RESET_FLAGS and depth=0 immediately (asynchronous). A pop after release -> unf_err=1.
